// File: rtl/liang_pkg.sv
// Shared types for the core memory-port arbiter.
//   pc_t / inst_t : IFU fetch address and instruction data
//   arb_state_e   : arbiter FSM states
//   arb_owner_e   : which requester owns the outstanding transaction
//   mem_req_t     : latched memory request payload
package liang_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_req_t;

endpackage

// File: rtl/pipe_mem_arb_timer.sv
// Response timeout counter for the memory arbiter.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear (takes priority over en_i)
//   en_i          : count one cycle
//   timeout_o     : high during the RESP_TIMEOUT-th enabled cycle since the last clear
module pipe_mem_arb_timer #(
    parameter int unsigned RESP_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(RESP_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Count holds the number of already-elapsed waiting cycles, so the
    // current cycle is the last one allowed when it equals RESP_TIMEOUT-1.
    assign timeout_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares the single core memory port between IFU fetches and LSU accesses.
// One outstanding transaction; responses routed back to the owner; fetch
// responses made stale by flush_i are dropped; WAIT is bounded by a timeout.
// Ports:
//   clk_i, rst_ni, flush_i
//   IFU : if_req_i, if_addr_i -> if_gnt_o (comb), if_rvalid_o, if_rdata_o
//   LSU : ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i
//         -> ls_gnt_o (comb), ls_rvalid_o, ls_rdata_o
//   MEM : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
//         <- mem_gnt_i, mem_rvalid_i, mem_rdata_i
//   err_o : one-cycle pulse on response timeout
// Macro MEM_ARB_RR_EN: round-robin arbitration in IDLE instead of LSU priority.
module pipe_mem_arbiter
    import liang_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        if_req_i,
    input  pc_t         if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output inst_t       if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [3:0]  ls_wmask_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wmask_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);

    arb_state_e  state_q;
    arb_owner_e  owner_q;
    mem_req_t    req_q;
    logic        mem_req_q;
    logic        drop_q;
    logic        if_rvalid_q;
    logic        ls_rvalid_q;
    logic        err_q;
    inst_t       if_rdata_q;
    logic [31:0] ls_rdata_q;

    logic        if_cand;
    logic        pick_ls;
    logic        pick_if;
    logic        timer_en;
    logic        timeout;
    logic        resp_done;
    logic        resp_drop;
    logic [31:0] resp_data;

`ifdef MEM_ARB_RR_EN
    arb_owner_e  last_owner_q;
`endif

    // A flush kills any fetch about to be issued.
    assign if_cand = if_req_i & ~flush_i;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        // On a tie, serve whoever was not served last.
        pick_ls = ls_req_i & (~if_cand | (last_owner_q == OWN_IF));
`else
        pick_ls = ls_req_i;
`endif
        pick_if = if_cand & ~pick_ls;
    end

    assign ls_gnt_o = (state_q == IDLE) & pick_ls;
    assign if_gnt_o = (state_q == IDLE) & pick_if;

    assign timer_en  = (state_q == WAIT);
    // A real response in the timeout cycle still wins.
    assign resp_done = mem_rvalid_i | timeout;
    assign resp_data = mem_rvalid_i ? mem_rdata_i : '0;
    // Flush in the response cycle itself also drops the fetch.
    assign resp_drop = drop_q | flush_i;

    pipe_mem_arb_timer #(
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (~timer_en),
        .en_i      (timer_en),
        .timeout_o (timeout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            req_q        <= '0;
            mem_req_q    <= 1'b0;
            drop_q       <= 1'b0;
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= OWN_IF;
`endif
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (pick_ls) begin
                        owner_q       <= OWN_LS;
                        req_q.we      <= ls_we_i;
                        req_q.addr    <= ls_addr_i;
                        req_q.wdata   <= ls_wdata_i;
                        req_q.wmask   <= ls_wmask_i;
                        mem_req_q     <= 1'b1;
                        state_q       <= REQ;
`ifdef MEM_ARB_RR_EN
                        last_owner_q  <= OWN_LS;
`endif
                    end else if (pick_if) begin
                        owner_q       <= OWN_IF;
                        req_q.we      <= 1'b0;
                        req_q.addr    <= if_addr_i;
                        req_q.wdata   <= '0;
                        req_q.wmask   <= '0;
                        mem_req_q     <= 1'b1;
                        state_q       <= REQ;
`ifdef MEM_ARB_RR_EN
                        last_owner_q  <= OWN_IF;
`endif
                    end
                end
                REQ: begin
                    if (flush_i && owner_q == OWN_IF) begin
                        drop_q <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_done) begin
                        err_q <= ~mem_rvalid_i;
                        if (owner_q == OWN_LS) begin
                            ls_rvalid_q <= 1'b1;
                            ls_rdata_q  <= resp_data;
                        end else if (!resp_drop) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= resp_data;
                        end
                        drop_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (flush_i && owner_q == OWN_IF) begin
                        drop_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = req_q.we;
    assign mem_addr_o  = req_q.addr;
    assign mem_wdata_o = req_q.wdata;
    assign mem_wmask_o = req_q.wmask;
    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rvalid_o = ls_rvalid_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign err_o       = err_q;

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares the single core memory port between IFU instruction fetch and LSU data access.
- Sits between pipe_ifu/pipe_lsu and the memory/bus adapter.
- Serialises requests, one outstanding transaction at a time; routes responses back to the owner.
- Discards fetch responses made stale by a pipeline flush; enforces a response timeout.

Parameters:
- RESP_TIMEOUT, 255: max cycles in WAIT before a forced error response; must be ≥2.
- CNT_W, 8: timeout counter width; must satisfy RESP_TIMEOUT < 2^CNT_W.

Ports:
- clk_i in 1: clock
- rst_ni in 1: asynchronous active-low reset
- flush_i in 1: pipeline flush, invalidates in-flight fetch
- if_req_i in 1: IFU read request
- if_addr_i in 32: fetch address
- if_gnt_o out 1: IFU request accepted
- if_rvalid_o out 1: fetch data valid, 1-cycle pulse
- if_rdata_o out 32: fetch data
- ls_req_i in 1: LSU request
- ls_we_i in 1: LSU write
- ls_addr_i in 32: LSU address
- ls_wdata_i in 32: LSU write data
- ls_wmask_i in 4: byte enables
- ls_gnt_o out 1: LSU request accepted
- ls_rvalid_o out 1: LSU response valid (reads and writes)
- ls_rdata_o out 32: LSU read data
- mem_req_o out 1: memory request
- mem_we_o, mem_addr_o (32), mem_wdata_o (32), mem_wmask_o (4) out: request payload
- mem_gnt_i in 1: memory accepted request
- mem_rvalid_i in 1: memory response valid
- mem_rdata_i in 32: memory read data
- err_o out 1: timeout pulse

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset:
  - State IDLE; all outputs 0; payload registers 0; drop flag and counter cleared.
  - Reset mid-transaction abandons it; the memory side must also be reset.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Winner chosen combinationally.
  - LSU has fixed priority. IFU request is masked when flush_i=1.
  - The winner's gnt_o is asserted in the same cycle.
  - Winner's payload and owner are latched. IFU payload: we=0, wmask=0.
  - Next state REQ. No request: stay in IDLE.
- REQ:
  - mem_req_o=1 with the latched payload.
  - Payload is stable until mem_gnt_i=1, then next state WAIT.
- WAIT:
  - mem_req_o=0; counter increments each cycle.
  - On mem_rvalid_i: the owner's rvalid_o pulses for 1 cycle with rdata=mem_rdata_i; next state IDLE.
  - mem_rvalid_i is ignored outside WAIT. Memory never returns rvalid in the gnt cycle.
- Latency: request to first mem_req_o is 1 cycle. The earliest new capture is the cycle after rvalid (IDLE cycle).
- Flush:
  - flush_i while the owner is IFU in REQ or WAIT sets the drop flag.
  - The transaction still completes on the bus, but if_rvalid_o is suppressed; the flag clears on return to IDLE.
  - flush_i has no effect on an LSU-owned transaction.
- Timeout:
  - If the counter reaches RESP_TIMEOUT in WAIT, err_o pulses 1 cycle.
  - The owner's rvalid_o pulses with rdata=0, unless IFU-dropped. Next state IDLE.
- Simultaneous events:
  - mem_rvalid_i and timeout in the same cycle: rvalid wins, no err_o.
  - flush_i in the same cycle as IFU mem_rvalid_i: the response is dropped.
- Outputs are registered except if_gnt_o/ls_gnt_o; mem payload comes from registers only.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined:
  - IDLE arbitration is round-robin. A last-owner register gives priority to the requester not served last.
  - Reset value of last owner = IFU, so LSU wins the first tie.
- Undefined: LSU fixed priority, no extra state.

Decomposition:
- liang_pkg:
  - arb_state_e (IDLE/REQ/WAIT).
  - arb_owner_e (OWN_IF/OWN_LS).
  - mem_req_t struct (we, addr, wdata, wmask).
  - Reuse of pc_t/inst_t for the IFU address/data.
- Sub-module pipe_mem_arb_timer: counter with clear/enable and a timeout flag. Everything else stays flat.

Test Plan:
- Single fetch:
  - Stimulus: if_req_i=1, addr 0x80000000; mem_gnt_i 2 cycles later; rvalid 3 cycles after that, rdata 0x00000413.
  - Required: if_gnt_o in cycle 0; mem_addr_o stable 0x80000000 through REQ; if_rvalid_o pulse with 0x00000413.
- Simultaneous requests:
  - Stimulus: if_req_i and ls_req_i (we=1, addr 0x80001000, wdata 0xDEADBEEF, mask 0xF) in the same cycle.
  - Required: ls_gnt_o first, memory write seen, ls_rvalid_o, then IFU served. With MEM_ARB_RR_EN, a second tie goes to IFU.
- Flush drop:
  - Stimulus: IFU transaction in WAIT, flush_i pulse, then rvalid with 0x12345678.
  - Required: no if_rvalid_o; next IFU request (addr 0x80000100) granted normally.
- Flush mask:
  - Stimulus: flush_i and if_req_i together in IDLE.
  - Required: no if_gnt_o that cycle; grant in the next cycle.
- Timeout:
  - Stimulus: RESP_TIMEOUT=4, no mem_rvalid_i.
  - Required: err_o and ls_rvalid_o with rdata 0 after 4 WAIT cycles; return to IDLE.
- Reset:
  - Stimulus: rst_ni low mid-WAIT.
  - Required: all outputs 0 immediately (asynchronous), FSM IDLE.
